// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, ALU opcodes, frontend state encoding and byte-lane helpers
package alu_pkg;

    localparam int unsigned NB_DATA  = 32;
    localparam int unsigned NB_OP    = 6;
    localparam int unsigned NB_BYTE  = 8;
    localparam int unsigned NB_SHAMT = 5;

    localparam int unsigned FRAME_OPERAND_BYTES = 4;
    localparam int unsigned RESULT_BYTES        = 4;

    // MIPS funct-field opcodes understood by the ALU
    localparam logic [NB_OP-1:0] ALU_SLL     = 6'h00;
    localparam logic [NB_OP-1:0] ALU_SRL     = 6'h02;
    localparam logic [NB_OP-1:0] ALU_SRA     = 6'h03;
    localparam logic [NB_OP-1:0] ALU_ADD     = 6'h20;
    localparam logic [NB_OP-1:0] ALU_ADDU    = 6'h21;
    localparam logic [NB_OP-1:0] ALU_SUB     = 6'h22;
    localparam logic [NB_OP-1:0] ALU_SUBU    = 6'h23;
    localparam logic [NB_OP-1:0] ALU_AND     = 6'h24;
    localparam logic [NB_OP-1:0] ALU_OR      = 6'h25;
    localparam logic [NB_OP-1:0] ALU_XOR     = 6'h26;
    localparam logic [NB_OP-1:0] ALU_NOR     = 6'h27;
    localparam logic [NB_OP-1:0] ALU_SLT     = 6'h2A;
    localparam logic [NB_OP-1:0] ALU_IDLE_OP = 6'h3F;

    typedef enum logic [2:0] {
        ST_RX_OP    = 3'd0,
        ST_RX_SHAMT = 3'd1,
        ST_RX_A     = 3'd2,
        ST_RX_B     = 3'd3,
        ST_EXEC     = 3'd4,
        ST_TX_SEND  = 3'd5,
        ST_TX_WAIT  = 3'd6
    } fe_state_e;

    // Replace one byte lane of a word (lane 0 = least significant byte)
    function automatic logic [NB_DATA-1:0] insert_byte(
        input logic [NB_DATA-1:0] word,
        input logic [1:0]         lane,
        input logic [NB_BYTE-1:0] data
    );
        logic [NB_DATA-1:0] result;
        result = word;
        result[lane*NB_BYTE +: NB_BYTE] = data;
        return result;
    endfunction

    function automatic logic [NB_BYTE-1:0] get_byte(
        input logic [NB_DATA-1:0] word,
        input logic [1:0]         lane
    );
        return word[lane*NB_BYTE +: NB_BYTE];
    endfunction

endpackage

// File: rtl/alu_uart_frontend_if.sv
// rtl/alu_uart_frontend_if.sv - UART byte handshakes and ALU operand/result bus of the frontend
// Ports (as signals):
//   i_rx_data/i_rx_done : received byte and its one-cycle strobe
//   i_tx_done           : transmitter finished the previous byte
//   i_alu_result        : combinational ALU result
//   o_alu_datoA/B, o_alu_op, o_alu_shamt : registered ALU inputs
//   o_tx_data/o_tx_start: byte and one-cycle start request to the transmitter
// master = frontend side, slave = UART/ALU side.
interface alu_uart_frontend_if;
    import alu_pkg::*;

    logic [NB_BYTE-1:0]  i_rx_data;
    logic                i_rx_done;
    logic                i_tx_done;
    logic [NB_DATA-1:0]  i_alu_result;
    logic [NB_DATA-1:0]  o_alu_datoA;
    logic [NB_DATA-1:0]  o_alu_datoB;
    logic [NB_OP-1:0]    o_alu_op;
    logic [NB_SHAMT-1:0] o_alu_shamt;
    logic [NB_BYTE-1:0]  o_tx_data;
    logic                o_tx_start;

    modport master (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        output o_alu_datoA, o_alu_datoB, o_alu_op, o_alu_shamt, o_tx_data, o_tx_start
    );

    modport slave (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        input  o_alu_datoA, o_alu_datoB, o_alu_op, o_alu_shamt, o_tx_data, o_tx_start
    );

endinterface

// File: rtl/frame_timeout_counter.sv
// rtl/frame_timeout_counter.sv - idle-clock watchdog for partially received frames
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_enable       : count only while a frame is partially received
//   i_clear        : a byte arrived this cycle, restart the idle count
//   o_expired      : high in the cycle whose edge completes TIMEOUT_CYCLES idle clocks
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module frame_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam bit          TIMEOUT_ON = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] LAST_IDLE = TIMEOUT_ON ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_W-1:0] count_q, count_d;
    logic             expired;

    // Expiry is flagged combinationally so the FSM aborts on the same edge
    // that would otherwise record the TIMEOUT_CYCLES-th idle clock.
    always_comb begin
        expired = TIMEOUT_ON && i_enable && !i_clear && (count_q == LAST_IDLE);
        count_d = count_q;
        if (!i_enable || i_clear || expired) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = expired;

endmodule

// File: rtl/alu_uart_frontend.sv
// rtl/alu_uart_frontend.sv - UART command-frame assembler and result serialiser for the MIPS ALU
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus            : alu_uart_frontend_if.master (UART rx/tx handshakes, ALU operands/result)
//   o_busy         : high in every state except RX_OP
// Frame: op, shamt, A[4 bytes LSB first], B[4 bytes LSB first]; reply: result, 4 bytes LSB first.
module alu_uart_frontend
    import alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    alu_uart_frontend_if.master    bus,
    output logic                   o_busy
);

    fe_state_e           state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [NB_OP-1:0]    op_sh_q, op_sh_d;
    logic [NB_SHAMT-1:0] shamt_sh_q, shamt_sh_d;
    logic [NB_DATA-1:0]  a_sh_q, a_sh_d;
    logic [NB_DATA-1:0]  b_sh_q, b_sh_d;
    logic [NB_DATA-1:0]  alu_a_q, alu_a_d;
    logic [NB_DATA-1:0]  alu_b_q, alu_b_d;
    logic [NB_OP-1:0]    alu_op_q, alu_op_d;
    logic [NB_SHAMT-1:0] alu_shamt_q, alu_shamt_d;
    logic [NB_DATA-1:0]  tx_buf_q, tx_buf_d;
    logic [NB_BYTE-1:0]  tx_data_q, tx_data_d;
    logic                tx_start;
    logic                rx_state;
    logic                timeout_expired;

    // Only a partially received frame can time out; RX_OP waits forever.
    assign rx_state = (state_q == ST_RX_SHAMT) || (state_q == ST_RX_A) || (state_q == ST_RX_B);

    frame_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_enable  (rx_state),
        .i_clear   (bus.i_rx_done),
        .o_expired (timeout_expired)
    );

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        op_sh_d     = op_sh_q;
        shamt_sh_d  = shamt_sh_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_shamt_d = alu_shamt_q;
        tx_buf_d    = tx_buf_q;
        tx_data_d   = tx_data_q;
        tx_start    = 1'b0;

        unique case (state_q)
            ST_RX_OP: begin
                if (bus.i_rx_done) begin
                    op_sh_d = bus.i_rx_data[NB_OP-1:0];
                    state_d = ST_RX_SHAMT;
                end
            end

            ST_RX_SHAMT: begin
                if (bus.i_rx_done) begin
                    shamt_sh_d = bus.i_rx_data[NB_SHAMT-1:0];
                    byte_cnt_d = 2'd0;
                    state_d    = ST_RX_A;
                end
            end

            ST_RX_A: begin
                if (bus.i_rx_done) begin
                    a_sh_d = insert_byte(a_sh_q, byte_cnt_q, bus.i_rx_data);
                    if (byte_cnt_q == 2'(FRAME_OPERAND_BYTES - 1)) begin
                        byte_cnt_d = 2'd0;
                        state_d    = ST_RX_B;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end

            ST_RX_B: begin
                if (bus.i_rx_done) begin
                    if (byte_cnt_q == 2'(FRAME_OPERAND_BYTES - 1)) begin
                        // All ALU inputs switch on one edge so the ALU never
                        // sees a half-updated command.
                        alu_op_d    = op_sh_q;
                        alu_shamt_d = shamt_sh_q;
                        alu_a_d     = a_sh_q;
                        alu_b_d     = insert_byte(b_sh_q, byte_cnt_q, bus.i_rx_data);
                        byte_cnt_d  = 2'd0;
                        state_d     = ST_EXEC;
                    end else begin
                        b_sh_d     = insert_byte(b_sh_q, byte_cnt_q, bus.i_rx_data);
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end

            ST_EXEC: begin
                // ALU inputs have been stable for a full cycle here
                tx_buf_d   = bus.i_alu_result;
                tx_data_d  = get_byte(bus.i_alu_result, 2'd0);
                byte_cnt_d = 2'd0;
                state_d    = ST_TX_SEND;
            end

            ST_TX_SEND: begin
                tx_start = 1'b1;
                state_d  = ST_TX_WAIT;
            end

            ST_TX_WAIT: begin
                if (bus.i_tx_done) begin
                    if (byte_cnt_q == 2'(RESULT_BYTES - 1)) begin
                        byte_cnt_d = 2'd0;
                        state_d    = ST_RX_OP;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        tx_data_d  = get_byte(tx_buf_q, byte_cnt_q + 2'd1);
                        state_d    = ST_TX_SEND;
                    end
                end
            end

            default: begin
                state_d = ST_RX_OP;
            end
        endcase

        // A stalled partial frame is discarded; the ALU keeps its last command.
        if (rx_state && timeout_expired) begin
            state_d    = ST_RX_OP;
            byte_cnt_d = 2'd0;
            op_sh_d    = '0;
            shamt_sh_d = '0;
            a_sh_d     = '0;
            b_sh_d     = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_RX_OP;
            byte_cnt_q  <= 2'd0;
            op_sh_q     <= '0;
            shamt_sh_q  <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= ALU_IDLE_OP;
            alu_shamt_q <= '0;
            tx_buf_q    <= '0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            op_sh_q     <= op_sh_d;
            shamt_sh_q  <= shamt_sh_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_shamt_q <= alu_shamt_d;
            tx_buf_q    <= tx_buf_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign bus.o_alu_datoA = alu_a_q;
    assign bus.o_alu_datoB = alu_b_q;
    assign bus.o_alu_op    = alu_op_q;
    assign bus.o_alu_shamt = alu_shamt_q;
    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_tx_start  = tx_start;
    assign o_busy          = (state_q != ST_RX_OP);

endmodule

// File: tb/tb_alu_uart_frontend.sv
// tb/tb_alu_uart_frontend.sv - directed scoreboard bench for alu_uart_frontend with a behavioural ALU
module tb_alu_uart_frontend;
    import alu_pkg::*;

    logic i_clk;
    logic i_reset;
    logic o_busy;

    alu_uart_frontend_if bus();

    alu_uart_frontend #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus),
        .o_busy  (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] alu_model(input logic [5:0] op, input logic [4:0] sh,
                                              input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD, ALU_ADDU: return a + b;
            ALU_SUB, ALU_SUBU: return a - b;
            ALU_AND:           return a & b;
            ALU_OR:            return a | b;
            ALU_XOR:           return a ^ b;
            ALU_NOR:           return ~(a | b);
            ALU_SLT:           return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL:           return b << sh;
            ALU_SRL:           return b >> sh;
            ALU_SRA:           return $unsigned($signed(b) >>> sh);
            default:           return 32'd0;
        endcase
    endfunction

    always_comb bus.i_alu_result = alu_model(bus.o_alu_op, bus.o_alu_shamt,
                                             bus.o_alu_datoA, bus.o_alu_datoB);

    int unsigned compared;
    int unsigned mismatched;
    logic [7:0]  exp_q[$];

    // expected ALU input registers
    logic [5:0]  m_op;
    logic [4:0]  m_sh;
    logic [31:0] m_a;
    logic [31:0] m_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_op = 6'h3F;
        m_sh = 5'd0;
        m_a  = 32'd0;
        m_b  = 32'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(posedge i_clk); #1;
        bus.i_rx_done = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic send_frame(input string tag, input logic [7:0] op, input logic [7:0] sh,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_result);
        send_byte(op);
        send_byte(sh);
        for (int i = 0; i < 4; i++) send_byte(a[i*8 +: 8]);
        for (int i = 0; i < 3; i++) send_byte(b[i*8 +: 8]);
        chk({tag, " op_held"}, 32'(bus.o_alu_op), 32'(m_op));
        chk({tag, " b_held"}, bus.o_alu_datoB, m_b);
        // last byte: edge N
        bus.i_rx_data = b[31:24];
        bus.i_rx_done = 1'b1;
        @(posedge i_clk); #1;
        bus.i_rx_done = 1'b0;
        m_op = op[5:0];
        m_sh = sh[4:0];
        m_a  = a;
        m_b  = b;
        chk({tag, " alu_op"}, 32'(bus.o_alu_op), 32'(m_op));
        chk({tag, " alu_shamt"}, 32'(bus.o_alu_shamt), 32'(m_sh));
        chk({tag, " alu_a"}, bus.o_alu_datoA, m_a);
        chk({tag, " alu_b"}, bus.o_alu_datoB, m_b);
        chk({tag, " start_n"}, 32'(bus.o_tx_start), 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_result[i*8 +: 8]);
        @(posedge i_clk); #1;
        chk({tag, " start_latency"}, 32'(bus.o_tx_start), 32'd1);
    endtask

    task automatic get_tx_byte(input string tag, input bit inject_rx);
        logic [7:0] exp_b;
        for (int i = 0; i < 10 && !bus.o_tx_start; i++) begin
            @(posedge i_clk); #1;
        end
        chk({tag, " tx_start"}, 32'(bus.o_tx_start), 32'd1);
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        chk({tag, " tx_data"}, 32'(bus.o_tx_data), 32'(exp_b));
        @(posedge i_clk); #1;
        chk({tag, " start_one_cycle"}, 32'(bus.o_tx_start), 32'd0);
        if (inject_rx) begin
            bus.i_rx_data = 8'h55;
            bus.i_rx_done = 1'b1;
            @(posedge i_clk); #1;
            bus.i_rx_done = 1'b0;
            chk({tag, " busy_after_drop"}, 32'(o_busy), 32'd1);
        end
        repeat (2) @(posedge i_clk);
        #1;
        chk({tag, " tx_data_held"}, 32'(bus.o_tx_data), 32'(exp_b));
        bus.i_tx_done = 1'b1;
        @(posedge i_clk); #1;
        bus.i_tx_done = 1'b0;
    endtask

    task automatic get_reply(input string tag, input int inject_at);
        for (int i = 0; i < 4; i++) get_tx_byte($sformatf("%s byte%0d", tag, i), i == inject_at);
        chk({tag, " idle_after"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        model_reset();
        i_reset       = 1'b1;
        bus.i_rx_data = 8'h00;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        chk("reset alu_a", bus.o_alu_datoA, 32'd0);
        chk("reset alu_b", bus.o_alu_datoB, 32'd0);
        chk("reset alu_op", 32'(bus.o_alu_op), 32'h3F);
        chk("reset alu_shamt", 32'(bus.o_alu_shamt), 32'd0);
        chk("reset tx_data", 32'(bus.o_tx_data), 32'd0);
        chk("reset tx_start", 32'(bus.o_tx_start), 32'd0);
        chk("reset busy", 32'(o_busy), 32'd0);

        send_frame("add", 8'h20, 8'h00, 32'd5, 32'd7, 32'h0000000C);
        get_reply("add", -1);

        send_frame("sub", 8'h22, 8'h00, 32'd3, 32'd5, 32'hFFFFFFFE);
        get_reply("sub", -1);

        send_frame("sll", 8'h00, 8'h04, 32'd0, 32'd1, 32'h00000010);
        get_reply("sll", -1);

        // upper op/shamt bits are ignored
        send_frame("sra", 8'hC3, 8'hE4, 32'd0, 32'h80000000, 32'hF8000000);
        get_reply("sra", -1);

        // timeout: 3 bytes then exactly 16 idle clocks
        send_byte(8'h20);
        send_byte(8'h00);
        bus.i_rx_data = 8'h05;
        bus.i_rx_done = 1'b1;
        @(posedge i_clk); #1;
        bus.i_rx_done = 1'b0;
        repeat (15) @(posedge i_clk);
        #1;
        chk("timeout busy_at_15", 32'(o_busy), 32'd1);
        @(posedge i_clk); #1;
        chk("timeout busy_at_16", 32'(o_busy), 32'd0);
        chk("timeout alu_op", 32'(bus.o_alu_op), 32'(m_op));
        chk("timeout alu_a", bus.o_alu_datoA, m_a);
        chk("timeout alu_b", bus.o_alu_datoB, m_b);
        send_frame("add_after_to", 8'h20, 8'h00, 32'd5, 32'd7, 32'h0000000C);
        get_reply("add_after_to", -1);

        // rx strobe in TX_WAIT is dropped
        send_frame("and", 8'h24, 8'h00, 32'hF0F0FFFF, 32'h0F0F00FF, 32'h000000FF);
        get_reply("and", 1);
        send_frame("or", 8'h25, 8'h00, 32'h12340000, 32'h00005678, 32'h12345678);
        get_reply("or", -1);

        // reset after the second reply byte
        send_frame("xor", 8'h26, 8'h00, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F);
        get_tx_byte("xor byte0", 1'b0);
        get_tx_byte("xor byte1", 1'b0);
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        exp_q.delete();
        model_reset();
        chk("midtx_reset busy", 32'(o_busy), 32'd0);
        chk("midtx_reset tx_start", 32'(bus.o_tx_start), 32'd0);
        chk("midtx_reset tx_data", 32'(bus.o_tx_data), 32'd0);
        chk("midtx_reset alu_op", 32'(bus.o_alu_op), 32'h3F);
        chk("midtx_reset alu_a", bus.o_alu_datoA, 32'd0);
        bus.i_tx_done = 1'b1;
        @(posedge i_clk); #1;
        bus.i_tx_done = 1'b0;
        @(posedge i_clk); #1;
        chk("stray_tx_done busy", 32'(o_busy), 32'd0);
        chk("stray_tx_done tx_start", 32'(bus.o_tx_start), 32'd0);
        send_frame("nor", 8'h27, 8'h00, 32'd0, 32'd0, 32'hFFFFFFFF);
        get_reply("nor", -1);

        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
